// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 SDF FFT stage blocks.
package fft_pkg;
   localparam int LANES  = 16;
   localparam int DATA_W = 9;

   typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

   // lane j occupies bits [j*DATA_W +: DATA_W] when flattened
   typedef logic signed [LANES-1:0][DATA_W-1:0] bundle_t;
endpackage

// File: rtl/shift_reg.sv
// Bundle delay buffer for one SDF stage: DELAY_LENGTH-deep FIFO of 16-lane complex bundles.
// Read data is registered and valid the cycle after read.
module shift_reg
   import fft_pkg::*;
#(
   parameter int WIDTH        = DATA_W,
   parameter int DELAY_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   write,
   input  logic                   read,
   input  logic [LANES*WIDTH-1:0] din_real,
   input  logic [LANES*WIDTH-1:0] din_imag,
   output logic [LANES*WIDTH-1:0] dout_real,
   output logic [LANES*WIDTH-1:0] dout_imag,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = (DELAY_LENGTH > 1) ? $clog2(DELAY_LENGTH) : 1;
   localparam int BW = LANES * WIDTH;

   logic [BW-1:0] mem_real [DELAY_LENGTH];
   logic [BW-1:0] mem_imag [DELAY_LENGTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == (AW+1)'(DELAY_LENGTH));
   assign empty = (count == '0);
   assign do_rd = read & ~empty;
   assign do_wr = write & (~full | do_rd);

   // a write landing on a full buffer stores zeros
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_real[wr_ptr] <= full ? '0 : din_real;
         mem_imag[wr_ptr] <= full ? '0 : din_imag;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dout_real <= '0;
         dout_imag <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= (wr_ptr == AW'(DELAY_LENGTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr    <= (rd_ptr == AW'(DELAY_LENGTH-1)) ? '0 : rd_ptr + 1'b1;
            dout_real <= mem_real[rd_ptr];
            dout_imag <= mem_imag[rd_ptr];
         end
         if (do_wr && !do_rd)
            count <= count + 1'b1;
         else if (do_rd && !do_wr)
            count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/bf_pair_sched.sv
// Butterfly-pair scheduler for one radix-2 SDF stage; optional frame counter
// enabled by defining BF_PAIR_SCHED_FRAME_CNT_EN.
//
// state | meaning
// FILL  | writing first half-frame bundles into the delay buffer
// PAIR  | popping one stored bundle per incoming bundle, emitting aligned pairs
module bf_pair_sched
   import fft_pkg::*;
#(
   parameter int WIDTH        = DATA_W,
   parameter int DELAY_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_real,
   input  logic [LANES*WIDTH-1:0] in_imag,
   output logic                   buf_write,
   output logic                   buf_read,
   output logic [LANES*WIDTH-1:0] buf_din_real,
   output logic [LANES*WIDTH-1:0] buf_din_imag,
   input  logic [LANES*WIDTH-1:0] buf_dout_real,
   input  logic [LANES*WIDTH-1:0] buf_dout_imag,
   input  logic                   buf_full,
   input  logic                   buf_empty,
   output logic                   out_valid,
   output logic [LANES*WIDTH-1:0] out_a_real,
   output logic [LANES*WIDTH-1:0] out_a_imag,
   output logic [LANES*WIDTH-1:0] out_b_real,
   output logic [LANES*WIDTH-1:0] out_b_imag,
   output logic                   out_last,
   output logic                   err
`ifdef BF_PAIR_SCHED_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_cnt
`endif
);
   localparam int CW = (DELAY_LENGTH > 1) ? $clog2(DELAY_LENGTH) : 1;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          cnt_last;
   logic          err_hit;

   assign cnt_last     = (cnt == CW'(DELAY_LENGTH-1));
   assign buf_din_real = in_real;
   assign buf_din_imag = in_imag;

   // stale buffer output is hidden outside valid pairs
   assign out_a_real = out_valid ? buf_dout_real : '0;
   assign out_a_imag = out_valid ? buf_dout_imag : '0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      in_ready  = 1'b0;
      buf_write = 1'b0;
      buf_read  = 1'b0;
      err_hit   = 1'b0;
      case (state)
         FILL: begin
            in_ready  = ~buf_full;
            buf_write = in_valid & ~buf_full;
            err_hit   = in_valid & buf_full;
            if (buf_write) begin
               if (cnt_last) begin
                  cnt_nxt   = '0;
                  state_nxt = PAIR;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         PAIR: begin
            in_ready = ~buf_empty;
            buf_read = in_valid & ~buf_empty;
            err_hit  = in_valid & buf_empty;
            if (buf_read) begin
               if (cnt_last) begin
                  cnt_nxt   = '0;
                  state_nxt = FILL;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= FILL;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_b_real <= '0;
         out_b_imag <= '0;
         err        <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         out_valid <= buf_read;
         out_last  <= buf_read & cnt_last;
         err       <= err | err_hit;
         if (buf_read) begin
            out_b_real <= in_real;
            out_b_imag <= in_imag;
         end
      end
   end

`ifdef BF_PAIR_SCHED_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         frame_cnt <= '0;
      else if (out_valid && out_last)
         frame_cnt <= frame_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_bf_pair_sched.sv
// Directed bench for bf_pair_sched with shift_reg as the delay buffer.
module tb_bf_pair_sched;
   import fft_pkg::*;

   localparam int BW = LANES * DATA_W;
   localparam int DL = 16;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_real;
   logic [BW-1:0] in_imag;
   logic          buf_write;
   logic          buf_read;
   logic [BW-1:0] buf_din_real;
   logic [BW-1:0] buf_din_imag;
   logic [BW-1:0] buf_dout_real;
   logic [BW-1:0] buf_dout_imag;
   logic          fifo_full;
   logic          fifo_empty;
   logic          force_empty;
   logic          buf_empty;
   logic          out_valid;
   logic [BW-1:0] out_a_real;
   logic [BW-1:0] out_a_imag;
   logic [BW-1:0] out_b_real;
   logic [BW-1:0] out_b_imag;
   logic          out_last;
   logic          err;
`ifdef BF_PAIR_SCHED_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   int n_chk;
   int n_bad;
   int cyc;
   int az_viol;
   int last_viol;

   int            acc[$];
   logic [BW-1:0] qar[$];
   logic [BW-1:0] qai[$];
   logic [BW-1:0] qbr[$];
   logic [BW-1:0] qbi[$];
   logic          ql[$];
   int            qc[$];

   assign buf_empty = fifo_empty | force_empty;

   bf_pair_sched #(.WIDTH(DATA_W), .DELAY_LENGTH(DL)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_real       (in_real),
      .in_imag       (in_imag),
      .buf_write     (buf_write),
      .buf_read      (buf_read),
      .buf_din_real  (buf_din_real),
      .buf_din_imag  (buf_din_imag),
      .buf_dout_real (buf_dout_real),
      .buf_dout_imag (buf_dout_imag),
      .buf_full      (fifo_full),
      .buf_empty     (buf_empty),
      .out_valid     (out_valid),
      .out_a_real    (out_a_real),
      .out_a_imag    (out_a_imag),
      .out_b_real    (out_b_real),
      .out_b_imag    (out_b_imag),
      .out_last      (out_last),
      .err           (err)
`ifdef BF_PAIR_SCHED_FRAME_CNT_EN
      ,
      .frame_cnt     (frame_cnt)
`endif
   );

   shift_reg #(.WIDTH(DATA_W), .DELAY_LENGTH(DL)) u_buf (
      .clk       (clk),
      .rstn      (rstn),
      .write     (buf_write),
      .read      (buf_read),
      .din_real  (buf_din_real),
      .din_imag  (buf_din_imag),
      .dout_real (buf_dout_real),
      .dout_imag (buf_dout_imag),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         qar.push_back(out_a_real);
         qai.push_back(out_a_imag);
         qbr.push_back(out_b_real);
         qbi.push_back(out_b_imag);
         ql.push_back(out_last);
         qc.push_back(cyc);
      end else begin
         if (out_a_real != '0 || out_a_imag != '0) az_viol <= az_viol + 1;
         if (out_last) last_viol <= last_viol + 1;
      end
   end

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk_real(input int v);
      bundle_t b;
      for (int j = 0; j < LANES; j++) b[j] = v[DATA_W-1:0];
      return b;
   endfunction

   function automatic logic [BW-1:0] mk_imag();
      bundle_t b;
      for (int j = 0; j < LANES; j++) b[j] = DATA_W'(j);
      return b;
   endfunction

   task automatic clear_q();
      acc.delete(); qar.delete(); qai.delete(); qbr.delete(); qbi.delete();
      ql.delete(); qc.delete();
   endtask

   task automatic do_reset();
      in_valid    = 1'b0;
      in_real     = '0;
      in_imag     = '0;
      force_empty = 1'b0;
      rstn        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk) #1;
      clear_q();
   endtask

   task automatic send(input int v, input bit gap);
      in_valid = 1'b1;
      in_real  = mk_real(v);
      in_imag  = mk_imag();
      @(negedge clk);
      chk($sformatf("in_ready v=%0d", v), BW'(in_ready), BW'(1));
      acc.push_back(cyc + 1);
      @(posedge clk) #1;
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk) #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag, input int off, input int ba, input int bb,
                              input int c0, input int sp);
      for (int i = 0; i < DL; i++) begin
         chk($sformatf("%s a_re[%0d]", tag, i), qar[off+i], mk_real(ba + i));
         chk($sformatf("%s a_im[%0d]", tag, i), qai[off+i], mk_imag());
         chk($sformatf("%s b_re[%0d]", tag, i), qbr[off+i], mk_real(bb + i));
         chk($sformatf("%s b_im[%0d]", tag, i), qbi[off+i], mk_imag());
         chk($sformatf("%s last[%0d]", tag, i), BW'(ql[off+i]), BW'(i == DL-1));
         chk($sformatf("%s cyc[%0d]", tag, i), BW'(qc[off+i]), BW'(c0 + sp*i));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0; n_bad = 0; cyc = 0; az_viol = 0; last_viol = 0;

      // reset state
      do_reset();
      chk("rst out_valid", BW'(out_valid), BW'(0));
      chk("rst out_last", BW'(out_last), BW'(0));
      chk("rst err", BW'(err), BW'(0));
      chk("rst out_b_re", out_b_real, '0);
      chk("rst buf_wr", BW'(buf_write), BW'(0));
      chk("rst in_ready", BW'(in_ready), BW'(1));

      // one frame, continuous
      for (int k = 0; k < 2*DL; k++) send(k, 1'b0);
      idle(4);
      chk("f1 npairs", BW'(qar.size()), BW'(DL));
      if (qar.size() == DL) check_frame("f1", 0, 0, DL, acc[DL], 1);

      // two back-to-back frames
      do_reset();
      for (int k = 0; k < 4*DL; k++) send(k, 1'b0);
      idle(4);
      chk("f2 acc_span", BW'(acc[4*DL-1] - acc[0]), BW'(4*DL-1));
      chk("f2 npairs", BW'(qar.size()), BW'(2*DL));
      if (qar.size() == 2*DL) begin
         check_frame("f2a", 0, 0, DL, acc[DL], 1);
         check_frame("f2b", DL, 2*DL, 3*DL, acc[3*DL], 1);
      end

      // in_valid toggling
      do_reset();
      for (int k = 0; k < 2*DL; k++) send(k, 1'b1);
      idle(4);
      chk("tg npairs", BW'(qar.size()), BW'(DL));
      if (qar.size() == DL) check_frame("tg", 0, 0, DL, acc[DL], 2);

      // underrun error in PAIR
      do_reset();
      for (int k = 0; k < DL; k++) send(k, 1'b0);
      force_empty = 1'b1;
      in_valid    = 1'b1;
      @(negedge clk);
      chk("er in_ready", BW'(in_ready), BW'(0));
      chk("er buf_read", BW'(buf_read), BW'(0));
      chk("er err_pre", BW'(err), BW'(0));
      @(negedge clk);
      chk("er err", BW'(err), BW'(1));
      chk("er out_valid", BW'(out_valid), BW'(0));
      in_valid    = 1'b0;
      force_empty = 1'b0;
      repeat (3) @(negedge clk);
      chk("er err_sticky", BW'(err), BW'(1));

      // reset mid-fill, then a fresh frame
      @(posedge clk) #1;
      in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("mr err_clr", BW'(err), BW'(0));
      @(negedge clk) rstn = 1'b1;
      @(posedge clk) #1;
      clear_q();
      for (int k = 0; k < 10; k++) send(200 + k, 1'b0);
      in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("mr out_valid", BW'(out_valid), BW'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk) #1;
      clear_q();
      for (int k = 0; k < 2*DL; k++) send(-100 + k, 1'b0);
      idle(4);
      chk("mr npairs", BW'(qar.size()), BW'(DL));
      if (qar.size() == DL) check_frame("mr", 0, -100, -100 + DL, acc[DL], 1);
      chk("mr err", BW'(err), BW'(0));

`ifdef BF_PAIR_SCHED_FRAME_CNT_EN
      do_reset();
      chk("fc rst", BW'(frame_cnt), BW'(0));
      for (int k = 0; k < 6*DL; k++) send(k & 8'hff, 1'b0);
      idle(4);
      chk("fc three", BW'(frame_cnt), BW'(3));
`endif

      chk("a_zero_outside_valid", BW'(az_viol), BW'(0));
      chk("last_outside_valid", BW'(last_viol), BW'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
